program_loader: RTL
===================

Name: program_loader

Overview:
- Byte-stream boot loader: the writer side of the SoC program memory that the CPU fetches from.
- Accepts a framed little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes the words sequentially into program memory starting at word address 0, then verifies an XOR checksum.
- Holds the CPU in reset until a load completes cleanly; sits beside the CPU inside the SoC, driving the program-memory write port.

Parameters:
- ADDR_WIDTH, 10, program-memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; re-arms the loader for a new frame.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts the byte this cycle.
- mem_we  output  1  program-memory write enable.
- mem_addr  output  ADDR_WIDTH  word address.
- mem_wdata  output  32  word to write.
- cpu_hold  output  1  CPU reset request, active high.
- done  output  1  frame loaded and checksum matched.
- error  output  1  frame rejected.
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current frame.

Behaviour:
- Frame format, in order:
  - LEN: 16-bit word count N, low byte first.
  - N words, each 4 bytes, least-significant byte first.
  - CSUM: 4 bytes, LSB first; must equal the XOR of all N words (0 when N=0).
- Byte transfer occurs when in_valid && in_ready.
- States: S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR.
- Reset (reset==0 at a clk edge):
  - state S_LEN0.
  - byte index 0, word index 0, checksum accumulator 0, words_loaded 0.
  - mem_we 0, mem_addr 0, mem_wdata 0.
  - cpu_hold 1, done 0, error 0.
  - Reset is also honoured mid-frame: the partial load is abandoned and no further writes occur.
- in_ready is 1 in S_LEN0/S_LEN1/S_DATA/S_CSUM, 0 in S_DONE/S_ERROR, and forced 0 in any cycle where start==1.
- S_LEN0: on transfer, latch the low byte, go to S_LEN1.
- S_LEN1: on transfer, form N.
  - N > 2**ADDR_WIDTH: go to S_ERROR; no writes occur.
  - N == 0: go to S_CSUM.
  - Otherwise: go to S_DATA.
- S_DATA:
  - Shift bytes into the assembly register.
  - On the 4th byte, the word is complete. The next cycle drives mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = word.
  - On that write cycle: word index and words_loaded increment, and the accumulator XORs the word.
  - Write latency is 1 cycle after the accepting edge. Back-to-back words are supported: a new byte may be accepted during the write cycle.
  - After word N is accepted, go to S_CSUM.
- S_CSUM:
  - After the 4th byte, compare against the accumulator, including the final word's XOR.
  - Match: S_DONE. Mismatch: S_ERROR.
  - The compare is registered: done/error rise 1–2 cycles after the last byte, never before the last mem_we.
- S_DONE: done=1, cpu_hold=0.
- S_ERROR: error=1, cpu_hold=1. Already-written words remain in memory.
- start pulse, in any state:
  - Next state S_LEN0; clear indices, words_loaded and accumulator.
  - done=0, error=0, cpu_hold=1.
  - A mem_we already pending from the previous cycle still completes.
  - start has priority over byte transfer in the same cycle.
- in_valid gaps: the FSM stalls with no state change.
- Arithmetic: all counters are unsigned. The word index never wraps, because N is bounded by the S_LEN1 check.

Decomposition:
- Shared package/header holds:
  - state encodings (3-bit localparams);
  - frame constants: LEN_BYTES=2, WORD_BYTES=4, CSUM_BYTES=4.
- One natural sub-module, byte_to_word_packer: accepts bytes, emits a 32-bit word plus a one-cycle word_valid, with a clear input. The FSM, checksum and memory interface stay in program_loader.

Test Plan:
- Nominal load:
  - Stream 02 00, 93 02 80 07, 93 02 80 0C, 00 00 00 0B.
  - Expect mem writes addr0=0x07800293 and addr1=0x0C800293.
  - Expect words_loaded=2, done=1, cpu_hold=0, error=0.
- Bad checksum:
  - Same frame with CSUM bytes 00 00 00 0C.
  - Expect both writes, then error=1, done=0, cpu_hold=1.
- Oversize (ADDR_WIDTH=4):
  - Send LEN 11 00 (N=17).
  - Expect error=1 right after LEN1, no mem_we, in_ready=0.
- Empty frame and backpressure:
  - Send 00 00 00 00 00 00, with in_valid low on alternating cycles.
  - Expect done=1, words_loaded=0, no mem_we, and no byte consumed while in_valid=0.
- Restart mid-frame:
  - Pulse start after 3 data bytes of word 0, then send the nominal frame.
  - Expect the stale bytes discarded, addr0=0x07800293, done=1.
- Reset mid-frame:
  - Drive reset=0 for one clk during S_DATA.
  - Expect all outputs at reset values, cpu_hold=1, and a subsequent nominal frame loads correctly.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings and frame
// layout constants.
package program_loader_pkg;

  // State encodings
  localparam logic [2:0] ST_LEN0  = 3'd0;
  localparam logic [2:0] ST_LEN1  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  typedef enum logic [2:0] {
    S_LEN0  = ST_LEN0,
    S_LEN1  = ST_LEN1,
    S_DATA  = ST_DATA,
    S_CSUM  = ST_CSUM,
    S_DONE  = ST_DONE,
    S_ERROR = ST_ERROR
  } state_t;

  // Frame layout, in bytes
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CSUM_BYTES = 4;

endpackage

// File: rtl/program_loader_byte_to_word_packer.sv
// Assembles little-endian bytes into 32-bit words.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   clear           drop any partially assembled word
//   byte_data/valid incoming byte and its strobe
//   word            last completed word (held until the next one completes)
//   word_valid      one-cycle pulse, the cycle after the final byte is taken
//   word_done_c     combinational: the byte offered now completes a word
module byte_to_word_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_done_c
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);
  localparam int unsigned SR_W  = 8 * (WORD_BYTES - 1);

  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sr;

  assign word_done_c = byte_valid && (cnt == CNT_W'(WORD_BYTES - 1));

  // Earlier bytes shift down so the first byte ends up least significant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (byte_valid) begin
        if (word_done_c) begin
          word       <= {byte_data, sr};
          word_valid <= 1'b1;
          cnt        <= '0;
        end else begin
          sr  <= {byte_data, sr[SR_W-1:8]};
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (LEN, N words, XOR checksum),
// writes the words to program memory from address 0 and releases the CPU
// once the checksum matches.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start                 re-arm for a new frame (wins over byte transfer)
//   in_data/valid/ready   byte stream handshake
//   mem_we/addr/wdata     program-memory write port
//   cpu_hold              CPU reset request
//   done, error           frame accepted / rejected
//   words_loaded          words written in the current frame
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned CAPACITY   = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W      = ADDR_WIDTH + 1;
  localparam int unsigned LEN_W      = 8 * LEN_BYTES;
  localparam int unsigned CSUM_IDX_W = $clog2(CSUM_BYTES);
  localparam int unsigned CSUM_SR_W  = 8 * (CSUM_BYTES - 1);

  state_t                state, state_next;
  logic [7:0]            len_lo, len_lo_next;
  logic [LEN_W-1:0]      len, len_next;
  logic [LEN_W-1:0]      len_in;
  logic [CSUM_IDX_W-1:0] csum_idx, csum_idx_next;
  logic [CSUM_SR_W-1:0]  csum_sr, csum_sr_next;
  logic [31:0]           csum_in;
  logic [31:0]           acc, acc_next;
  logic [CNT_W-1:0]      word_idx, word_idx_next;
  logic                  ready_state;
  logic                  xfer;
  logic                  pack_valid;
  logic                  word_done_c;

  assign ready_state  = (state == S_LEN0) || (state == S_LEN1) ||
                        (state == S_DATA) || (state == S_CSUM);
  assign in_ready     = ready_state && !start;
  assign xfer         = in_valid && in_ready;
  assign pack_valid   = xfer && (state == S_DATA);
  assign len_in       = {in_data, len_lo};
  assign csum_in      = {in_data, csum_sr};
  assign mem_addr     = word_idx[ADDR_WIDTH-1:0];
  assign words_loaded = word_idx;

  // mem_we/mem_wdata come straight from the packer's output registers,
  // giving the one-cycle write latency after the final byte.
  byte_to_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear       (start),
    .byte_data   (in_data),
    .byte_valid  (pack_valid),
    .word        (mem_wdata),
    .word_valid  (mem_we),
    .word_done_c (word_done_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_LEN0;
      len_lo   <= '0;
      len      <= '0;
      csum_idx <= '0;
      csum_sr  <= '0;
      acc      <= '0;
      word_idx <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state    <= state_next;
      len_lo   <= len_lo_next;
      len      <= len_next;
      csum_idx <= csum_idx_next;
      csum_sr  <= csum_sr_next;
      acc      <= acc_next;
      word_idx <= word_idx_next;
      done     <= (state_next == S_DONE);
      error    <= (state_next == S_ERROR);
      cpu_hold <= (state_next != S_DONE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next    = state;
    len_lo_next   = len_lo;
    len_next      = len;
    csum_idx_next = csum_idx;
    csum_sr_next  = csum_sr;
    acc_next      = acc;
    word_idx_next = word_idx;

    // Write cycle bookkeeping; a restart below discards it.
    if (mem_we) begin
      acc_next      = acc ^ mem_wdata;
      word_idx_next = word_idx + CNT_W'(1);
    end

    if (start) begin
      state_next    = S_LEN0;
      csum_idx_next = '0;
      acc_next      = '0;
      word_idx_next = '0;
    end else if (xfer) begin
      case (state)
        S_LEN0: begin
          len_lo_next = in_data;
          state_next  = S_LEN1;
        end
        S_LEN1: begin
          len_next = len_in;
          if (32'(len_in) > CAPACITY) begin
            state_next = S_ERROR;
          end else if (len_in == '0) begin
            state_next = S_CSUM;
          end else begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          // word_idx already counts every earlier word by the time a
          // word's final byte arrives.
          if (word_done_c && (32'(word_idx) + 32'd1 == 32'(len))) begin
            state_next = S_CSUM;
          end
        end
        S_CSUM: begin
          csum_idx_next = csum_idx + CSUM_IDX_W'(1);
          csum_sr_next  = {in_data, csum_sr[CSUM_SR_W-1:8]};
          // The final write has retired at least three cycles earlier,
          // so acc already includes the last word.
          if (csum_idx == CSUM_IDX_W'(CSUM_BYTES - 1)) begin
            state_next = (csum_in == acc) ? S_DONE : S_ERROR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
